multicycle_controller: RTL

Multi-cycle sequencer for the RISC-V datapath. It replaces the single-cycle opcode decoder with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It issues per-state strobes to the datapath and memory, waits on a memory ready handshake with a timeout, counts retired instructions and flags faults. The ALUOp output feeds the existing ALU control decoder unchanged.

---
 rtl/riscv_ctrl_pkg.sv | 32 +++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control sequencer.
// State encodings are visible on state_dbg, so their values are fixed.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_IALU) ||
               (op == OP_LOAD)  || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory request and flags expiry.
// MEM_TIMEOUT = 0 turns the timer off so the requester waits forever.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic ready,
    input  logic waiting,
    output logic expired
);

    localparam int CW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    logic [CW-1:0] wait_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear || ready || !waiting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A ready in the expiry cycle wins, hence the !ready term.
    assign expired = (MEM_TIMEOUT != 0) && waiting && !ready &&
                     (wait_cnt == CW'(LAST));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a
// memory-ready handshake, wait timeout, retire counter and sticky fault.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic             mdr_write,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state_dbg
);

    state_t     state, state_next;
    logic [6:0] op_q;
    logic       retire;
    logic       fault_set;
    logic [1:0] fault_kind;
    logic       waiting;
    logic       timer_clear;
    logic       expired;

    assign waiting     = (state == S_FETCH) || (state == S_MEM);
    assign timer_clear = (state_next != state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .ready   (mem_ready),
        .waiting (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            retired    <= '0;
            fault_code <= FAULT_NONE;
        end else begin
            state <= state_next;
            if (state == S_DECODE) op_q <= opcode;
            if (retire) retired <= retired + CNT_W'(1);
            if (fault_set) fault_code <= fault_kind;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem2reg    = 1'b0;
        mdr_write  = 1'b0;
        retire     = 1'b0;
        fault_set  = 1'b0;
        fault_kind = FAULT_NONE;

        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    pc_write   = 1'b1;
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    fault_set  = 1'b1;
                    fault_kind = FAULT_TIMEOUT;
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_next = S_EXECUTE;
                end else begin
                    fault_set  = 1'b1;
                    fault_kind = FAULT_ILLEGAL;
                    state_next = S_FAULT;
                end
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_RTYPE: begin
                        alu_op     = ALUOP_FUNCT;
                        state_next = S_WB;
                    end
                    OP_IALU: begin
                        alu_src    = 1'b1;
                        alu_op     = ALUOP_FUNCT;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src    = 1'b1;
                        state_next = S_MEM;
                    end
                    default: begin
                        fault_set  = 1'b1;
                        fault_kind = FAULT_ILLEGAL;
                        state_next = S_FAULT;
                    end
                endcase
            end
            S_MEM: begin
                // Address path held stable for the whole request.
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q != OP_LOAD);
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        mdr_write  = 1'b1;
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (expired) begin
                    fault_set  = 1'b1;
                    fault_kind = FAULT_TIMEOUT;
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = (op_q == OP_LOAD);
                if (op_q == OP_RTYPE || op_q == OP_IALU) begin
                    alu_src = (op_q == OP_IALU);
                    alu_op  = ALUOP_FUNCT;
                end
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    assign fault     = (state == S_FAULT);
    assign state_dbg = state;

endmodule
